noc_axi4_write_responder: RTL and testbench
===========================================

// Module: noc_axi4_write_responder
// PURPOSE
//  AXI4 write-channel responder (slave side), the far end of the bridge's AXI write master.
//  Accepts one AW burst of narrow beats and gathers them into a single cache-line write.
//  Presents the line to a memory-side backend, then returns a B response.
//  Used in chipset sims and FPGA loopback as a memory endpoint. One transaction outstanding.
// PARAMETERS
//  DAT_W    64   AXI W data width in bits (power of 2, 8..LINE_W)
//  LINE_W   512  backend line width in bits; MAX_BEATS = LINE_W/DAT_W
//  ID_W     16   AXI ID width
//  ADDR_W   64   AXI address width
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  s_axi_awid     in   ID_W       write address ID
//  s_axi_awaddr   in   ADDR_W     burst start address
//  s_axi_awlen    in   8          beats-1
//  s_axi_awsize   in   3          log2 bytes per beat
//  s_axi_awburst  in   2          burst type; only INCR (2'b01) supported
//  s_axi_awvalid  in   1          AW valid
//  s_axi_awready  out  1          AW ready
//  s_axi_wdata    in   DAT_W      write data
//  s_axi_wstrb    in   DAT_W/8    byte strobes
//  s_axi_wlast    in   1          last beat flag
//  s_axi_wvalid   in   1          W valid
//  s_axi_wready   out  1          W ready
//  s_axi_bid      out  ID_W       response ID (= latched awid)
//  s_axi_bresp    out  2          2'b00 OKAY, 2'b10 SLVERR
//  s_axi_bvalid   out  1          B valid
//  s_axi_bready   in   1          B ready
//  line_val       out  1          line write valid
//  line_addr      out  ADDR_W     awaddr with low log2(LINE_W/8) bits cleared
//  line_data      out  LINE_W     gathered line
//  line_strb      out  LINE_W/8   gathered byte enables (unwritten bytes 0)
//  line_rdy       in   1          backend accepts line
// BEHAVIOUR
//  Reset: state=IDLE; awready=1 and wready=0 (both from state), bvalid=0, line_val=0, bresp=0, bid=0.
//   line_data/line_strb also 0. Reset in any state aborts silently; partial data is dropped, no B.
//  FSM IDLE->DATA->(WRITE)->RESP->IDLE.
//   IDLE: awready=1; on AW handshake latch id/addr/len/size/burst, clear line_strb, beat_cnt=0.
//    err = (awburst!=INCR)|(awlen>MAX_BEATS-1)|(awsize>log2(DAT_W/8))|(awsize<log2(DAT_W/8) & awlen!=0).
//   DATA: wready=1. Each W handshake writes beat into slot = (awaddr[log2(LINE_W/8)-1:log2(DAT_W/8)]
//    + beat_cnt) mod MAX_BEATS; that slot's line_strb bytes are set to wstrb. Data is dropped if err.
//    wlast must be 1 exactly when beat_cnt==awlen; any mismatch sets err. The burst ends on
//    beat_cnt==awlen regardless of wlast. Then go to WRITE if !err, else go to RESP with SLVERR.
//   WRITE: line_val=1, outputs stable until line_rdy; on handshake -> RESP, bresp=OKAY.
//   RESP: bvalid=1, bid/bresp stable until bready; on handshake -> IDLE.
//  wready is 0 outside DATA (W before AW is held off; legal AXI). awready is 0 outside IDLE.
//  Latency, zero wait states: AW hs cycle 0; beats cycles 1..awlen+1; line_val the next cycle.
//   bvalid the cycle after the line handshake. Minimum AW-to-AW spacing is awlen+4 cycles.
//  beat_cnt is 8 bits wide; it never wraps because the burst terminates at awlen.
//  awlock/cache/prot/qos/region/user are not ported; the instantiator ties them off.
// TESTING
//  1 DAT_W=64, awaddr=0x1000, awlen=7, awsize=3, wdata=beat k, strb=FF
//    -> line_addr=0x1000; line_data slot k = k; line_strb all 1; bresp=00, bid=awid.
//  2 awaddr=0x1028, awlen=0, awsize=3, wstrb=0x0F -> slot 5; line_strb=0x0F<<40; other bytes 0.
//  3 awlen=8 -> wready for 9 beats, no line_val, bresp=10.
//  4 awlen=7 with wlast on beat 3 -> 8 beats still consumed, no line_val, bresp=10.
//  5 line_rdy low 6 cycles then bready low 10 cycles -> line_val, then bvalid/bid held; awready=0.
//  6 rst pulse after beat 4 of 8 -> all outputs at reset values; next burst completes OKAY.

Source files
------------

// File: rtl/noc_axi4_write_responder.sv
// rtl/noc_axi4_write_responder.sv - AXI4 write responder gathering one burst into a cache-line write
module noc_axi4_write_responder #(
    parameter int DAT_W  = 64,
    parameter int LINE_W = 512,
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DAT_W-1:0]      s_axi_wdata,
    input  logic [DAT_W/8-1:0]    s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic                  line_val,
    output logic [ADDR_W-1:0]     line_addr,
    output logic [LINE_W-1:0]     line_data,
    output logic [LINE_W/8-1:0]   line_strb,
    input  logic                  line_rdy
);
    localparam int MAX_BEATS  = LINE_W / DAT_W;
    localparam int STRB_W     = DAT_W / 8;
    localparam int BEAT_SHIFT = $clog2(STRB_W);
    localparam int LINE_SHIFT = $clog2(LINE_W / 8);
    localparam int SLOT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [8:0]        MAX_LEN     = 9'(MAX_BEATS - 1);
    localparam logic [2:0]        BEAT_SIZE   = 3'(BEAT_SHIFT);
    localparam logic [SLOT_W-1:0] SLOT_MASK   = SLOT_W'(MAX_BEATS - 1);
    localparam logic [1:0]        BURST_INCR  = 2'b01;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, DATA, WRITE, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         len;
    logic [7:0]         beat_cnt;
    logic               err;
    logic               aw_hs;
    logic               w_hs;
    logic               aw_err;
    logic               last_beat;
    logic               wlast_bad;
    logic [SLOT_W-1:0]  slot;

    assign aw_hs     = s_axi_awvalid & s_axi_awready;
    assign w_hs      = s_axi_wvalid & s_axi_wready;
    assign last_beat = (beat_cnt == len);
    // wlast must coincide exactly with the final counted beat
    assign wlast_bad = s_axi_wlast ^ last_beat;

    // Burst shapes that cannot be gathered into one line are rejected up front
    assign aw_err = (s_axi_awburst != BURST_INCR)
                  | ({1'b0, s_axi_awlen} > MAX_LEN)
                  | (s_axi_awsize > BEAT_SIZE)
                  | ((s_axi_awsize < BEAT_SIZE) & (s_axi_awlen != 8'd0));

    // Beats fill consecutive line slots starting at the address slot, wrapping within the line
    assign slot = (SLOT_W'(addr >> BEAT_SHIFT) + SLOT_W'(beat_cnt)) & SLOT_MASK;

    assign line_addr = {addr[ADDR_W-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (aw_hs) state_next = DATA;
            end
            DATA: begin
                if (w_hs && last_beat) state_next = (err | wlast_bad) ? RESP : WRITE;
            end
            WRITE: begin
                if (line_rdy) state_next = RESP;
            end
            RESP: begin
                if (s_axi_bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        line_val      = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (state)
            IDLE:    s_axi_awready = 1'b1;
            DATA:    s_axi_wready  = 1'b1;
            WRITE:   line_val      = 1'b1;
            RESP:    s_axi_bvalid  = 1'b1;
            default: s_axi_awready = 1'b0;
        endcase
    end

    // Burst context, beat gathering and response status
    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            len         <= '0;
            beat_cnt    <= '0;
            err         <= 1'b0;
            s_axi_bid   <= '0;
            s_axi_bresp <= RESP_OKAY;
            line_data   <= '0;
            line_strb   <= '0;
        end else begin
            if (aw_hs) begin
                s_axi_bid <= s_axi_awid;
                addr      <= s_axi_awaddr;
                len       <= s_axi_awlen;
                beat_cnt  <= '0;
                err       <= aw_err;
                line_strb <= '0;
            end
            if (w_hs) begin
                if (!err) begin
                    for (int s = 0; s < MAX_BEATS; s++) begin
                        if (slot == SLOT_W'(s)) begin
                            line_data[s*DAT_W +: DAT_W]   <= s_axi_wdata;
                            line_strb[s*STRB_W +: STRB_W] <= s_axi_wstrb;
                        end
                    end
                end
                beat_cnt <= beat_cnt + 8'd1;
                if (wlast_bad) err <= 1'b1;
                if (last_beat) s_axi_bresp <= (err | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end
            if ((state == WRITE) && line_rdy) begin
                s_axi_bresp <= RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_noc_axi4_write_responder.sv
// tb/tb_noc_axi4_write_responder.sv - self-checking bench for noc_axi4_write_responder
module tb_noc_axi4_write_responder;
    localparam int DAT_W  = 64;
    localparam int LINE_W = 512;
    localparam int ID_W   = 16;
    localparam int ADDR_W = 64;
    localparam int NBYTES = LINE_W / 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ID_W-1:0]      awid;
    logic [ADDR_W-1:0]    awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;
    logic [DAT_W-1:0]     wdata;
    logic [DAT_W/8-1:0]   wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;
    logic [ID_W-1:0]      bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic                 line_val;
    logic [ADDR_W-1:0]    line_addr;
    logic [LINE_W-1:0]    line_data;
    logic [NBYTES-1:0]    line_strb;
    logic                 line_rdy;

    always #5 clk = ~clk;

    noc_axi4_write_responder #(
        .DAT_W(DAT_W), .LINE_W(LINE_W), .ID_W(ID_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .line_val(line_val), .line_addr(line_addr), .line_data(line_data),
        .line_strb(line_strb), .line_rdy(line_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [DAT_W-1:0] beat_data[$];
    logic [7:0]       beat_strb[$];

    // Reference: a burst is good only if INCR, fits the line, full-width (or single narrow beat), wlast on final beat
    function automatic bit model_err(input logic [1:0] burst, input int len, input int size, input int wlast_at);
        return (burst != 2'b01) || (len > LINE_W / DAT_W - 1) || (size > 3) ||
               (size < 3 && len != 0) || (wlast_at != len);
    endfunction

    // Reference line image built byte by byte from the queued beats
    task automatic model_line(input logic [ADDR_W-1:0] a, input int len,
                              output logic [LINE_W-1:0] d, output logic [NBYTES-1:0] s,
                              output logic [LINE_W-1:0] m);
        int slot;
        d = '0; s = '0; m = '0;
        for (int k = 0; k <= len; k++) begin
            slot = int'(((a / 8) + k) % (LINE_W / DAT_W));
            for (int b = 0; b < 8; b++) begin
                if (beat_strb[k][b]) begin
                    s[slot*8 + b]         = 1'b1;
                    d[(slot*8 + b)*8 +: 8] = beat_data[k][b*8 +: 8];
                    m[(slot*8 + b)*8 +: 8] = 8'hFF;
                end
            end
        end
    endtask

    task automatic run_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input int len,
                             input int size, input logic [1:0] burst, input int wlast_at,
                             input int rdy_delay, input int b_delay, input string tag,
                             output logic [1:0] got_resp, output logic [NBYTES-1:0] got_strb);
        bit                exp_err;
        logic [LINE_W-1:0] ed;
        logic [NBYTES-1:0] es;
        logic [LINE_W-1:0] em;
        int                cyc;
        exp_err  = model_err(burst, len, size, wlast_at);
        got_strb = '0;
        if (len <= LINE_W / DAT_W - 1) model_line(a, len, ed, es, em);
        else begin ed = '0; es = '0; em = '0; end

        @(negedge clk);
        awid = id; awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 40) begin @(negedge clk); cyc++; end
        check({tag, "_awready"}, LINE_W'(awready), LINE_W'(1));
        @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wdata = beat_data[k]; wstrb = beat_strb[k]; wlast = (k == wlast_at); wvalid = 1'b1;
            check($sformatf("%s_wready_beat%0d", tag, k), LINE_W'(wready), LINE_W'(1));
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check({tag, "_wready_after"}, LINE_W'(wready), LINE_W'(0));
        if (!exp_err) begin
            check({tag, "_line_val"}, LINE_W'(line_val), LINE_W'(1));
            check({tag, "_line_addr"}, LINE_W'(line_addr), LINE_W'(a & ~64'h3F));
            check({tag, "_line_strb"}, LINE_W'(line_strb), LINE_W'(es));
            check({tag, "_line_data"}, line_data & em, ed);
            got_strb = line_strb;
            for (int d = 0; d < rdy_delay; d++) begin
                @(negedge clk);
                check({tag, "_line_hold"}, LINE_W'({line_val, awready, bvalid}), LINE_W'(3'b100));
            end
            line_rdy = 1'b1;
            @(negedge clk);
            line_rdy = 1'b0;
        end else begin
            check({tag, "_no_line_val"}, LINE_W'(line_val), LINE_W'(0));
        end
        check({tag, "_bvalid"}, LINE_W'(bvalid), LINE_W'(1));
        check({tag, "_bid"}, LINE_W'(bid), LINE_W'(id));
        check({tag, "_bresp"}, LINE_W'(bresp), LINE_W'(exp_err ? 2'b10 : 2'b00));
        got_resp = bresp;
        for (int d = 0; d < b_delay; d++) begin
            @(negedge clk);
            check({tag, "_b_hold"}, LINE_W'({bvalid, awready, bid, bresp}),
                  LINE_W'({1'b1, 1'b0, id, exp_err ? 2'b10 : 2'b00}));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_b_done"}, LINE_W'({bvalid, awready}), LINE_W'(2'b01));
    endtask

    task automatic fill_beats(input int len, input logic [7:0] strb, input bit counting);
        beat_data.delete(); beat_strb.delete();
        for (int k = 0; k <= len; k++) begin
            beat_data.push_back(counting ? DAT_W'(k) : {$urandom, $urandom});
            beat_strb.push_back(strb);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                len;
        int                size;
        logic [1:0]        burst;
        int                wlast_at;
        logic [7:0]        strb;
        logic [1:0]        exp_resp;
        logic [NBYTES-1:0] exp_strb;
    } vec_t;

    vec_t       vecs[9];
    logic [1:0] r_resp;
    logic [NBYTES-1:0] r_strb;

    initial begin
        vecs[0] = '{64'h1000, 7, 3, 2'b01, 7, 8'hFF, 2'b00, {NBYTES{1'b1}}};
        vecs[1] = '{64'h1028, 0, 3, 2'b01, 0, 8'h0F, 2'b00, NBYTES'(64'h0F) << 40};
        vecs[2] = '{64'h1000, 8, 3, 2'b01, 8, 8'hFF, 2'b10, '0};
        vecs[3] = '{64'h1000, 7, 3, 2'b01, 3, 8'hFF, 2'b10, '0};
        vecs[4] = '{64'h2000, 0, 2, 2'b01, 0, 8'hFF, 2'b00, NBYTES'(64'hFF)};
        vecs[5] = '{64'h2000, 1, 2, 2'b01, 1, 8'hFF, 2'b10, '0};
        vecs[6] = '{64'h2000, 3, 3, 2'b10, 3, 8'hFF, 2'b10, '0};
        vecs[7] = '{64'h2030, 3, 3, 2'b01, 3, 8'hFF, 2'b00,
                    (NBYTES'(64'hFFFF) << 48) | NBYTES'(64'hFFFF)};
        vecs[8] = '{64'h3000, 0, 4, 2'b01, 0, 8'hFF, 2'b10, '0};

        rst = 1'b1; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; line_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", LINE_W'({awready, wready, bvalid, line_val, bresp, bid}), LINE_W'(0) | (LINE_W'(1) << (ID_W + 5)));
        check("reset_line", {line_data, line_strb} != '0 ? LINE_W'(1) : LINE_W'(0), LINE_W'(0));

        for (int i = 0; i < 9; i++) begin
            fill_beats(vecs[i].len, vecs[i].strb, i == 0);
            run_burst(16'(16'h100 + i), vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                      vecs[i].wlast_at, 0, 0, $sformatf("vec%0d", i), r_resp, r_strb);
            check($sformatf("vec%0d_table_resp", i), LINE_W'(r_resp), LINE_W'(vecs[i].exp_resp));
            if (vecs[i].exp_resp == 2'b00)
                check($sformatf("vec%0d_table_strb", i), LINE_W'(r_strb), LINE_W'(vecs[i].exp_strb));
        end

        // Backpressure on both line and B channels
        fill_beats(7, 8'hFF, 1'b0);
        run_burst(16'hBEEF, 64'h5000, 7, 3, 2'b01, 7, 6, 10, "stall", r_resp, r_strb);

        // Reset in the middle of a burst drops it silently
        @(negedge clk);
        awid = 16'h77; awaddr = 64'h4000; awlen = 8'd7; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge clk);
        end
        wvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ctrl", LINE_W'({awready, wready, bvalid, line_val, bresp, bid}), LINE_W'(1) << (ID_W + 5));
        check("midrst_line_strb", LINE_W'(line_strb), LINE_W'(0));
        check("midrst_line_data", line_data, LINE_W'(0));
        fill_beats(7, 8'hFF, 1'b0);
        run_burst(16'h78, 64'h4000, 7, 3, 2'b01, 7, 0, 0, "post_rst", r_resp, r_strb);

        // Randomized bursts against the reference model
        for (int i = 0; i < 30; i++) begin
            int len, size, wl, rd, bd;
            logic [1:0] bt;
            logic [ADDR_W-1:0] a;
            len  = $urandom_range(0, 9) == 9 ? $urandom_range(8, 10) : $urandom_range(0, 7);
            size = $urandom_range(0, 9) == 0 ? $urandom_range(0, 5) : 3;
            bt   = $urandom_range(0, 9) == 0 ? 2'($urandom_range(0, 3)) : 2'b01;
            wl   = $urandom_range(0, 9) == 0 ? $urandom_range(0, len + 1) : len;
            rd   = $urandom_range(0, 3);
            bd   = $urandom_range(0, 3);
            a    = {$urandom, $urandom} & ~64'h7;
            fill_beats(len, 8'($urandom), 1'b0);
            run_burst(16'($urandom), a, len, size, bt, wl, rd, bd, $sformatf("rnd%0d", i), r_resp, r_strb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
